gnrl_freelist_64x4_module: RTL and testbench
============================================

# gnrl_freelist_64x4_module

64-entry free-list allocator for rename/issue resources. It holds a registered 64-bit free map and drives it into the 64-select-4 priority encoder. It grants up to four lowest-indexed free entries per cycle and reclaims up to four entries per cycle, with flush restore. It sits directly upstream of the encoder, feeding its bit map, and downstream of it, consuming and qualifying the four selected indices.

## Interface
- `RST_FREE_MAP`, default 64'hFFFF_FFFF_FFFF_FFFF: free map loaded on reset. Bit k = 1 means entry k is free.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `i_flush` in 1: restore the free map from `i_flush_free_map`.
- `i_flush_free_map` in 64: map loaded on flush.
- `i_alloc_cnt` in 3: requested allocations this cycle, 0..4. Values 5..7 are illegal and treated as 4.
- `o_alloc_gnt` in/out out 1: request accepted; all-or-nothing.
- `o_alloc_vld` out 4: lane k has a valid free index. Thermometer code.
- `o_alloc_idx_0..3` out 6 each: k-th lowest free index. Meaningful only when the matching `o_alloc_vld` bit is set.
- `i_free_vld` in 4: per-lane release valid.
- `i_free_idx_0..3` in 6 each: entry to release.
- `o_free_cnt` out 7: registered popcount of the free map, 0..64.
- `o_empty` out 1: `o_free_cnt == 0`.
- `o_dbl_free` out 1: registered one-cycle error pulse.

## Operation
- The registered map drives the encoder combinationally. `o_alloc_vld[k] = (o_free_cnt > k)`.
- Grant rule: `o_alloc_gnt = ~i_flush & (o_free_cnt >= i_alloc_cnt)`. `i_alloc_cnt == 0` gives a grant of 1 with no effect.
- Granted lanes are 0..`i_alloc_cnt`-1.
- `alloc_mask` is the OR of one-hot(`o_alloc_idx_k`) over granted lanes; it is zero when there is no grant.
- `free_mask` is the OR of one-hot(`i_free_idx_k`) over set `i_free_vld` lanes.
- Next state, normal cycle: `map <= (map & ~alloc_mask) | free_mask`. `o_free_cnt <= popcount(next map)`.
- Double free: a valid free index whose bit is already 1 in the current map, or two valid free lanes with the same index. Either case sets `o_dbl_free` next cycle. The map still applies the OR, and the count tracks the true popcount.
- Flush takes priority over everything. `map <= i_flush_free_map`, count = its popcount. Alloc and free are ignored that cycle, and `o_dbl_free <= 0`.
- Reset takes priority over flush. `map <= RST_FREE_MAP`, `o_free_cnt <= popcount(RST_FREE_MAP)` (64 by default), `o_dbl_free <= 0`. Combinational outputs follow from the reset map.

## Timing
- Alloc latency is 0: the indices are valid in the same cycle as the request. Allocated entries disappear from the map the next cycle.
- Free latency is 1: a released entry is allocatable no earlier than the cycle after `i_free_vld`. There is no bypass, so freed and allocated sets in one cycle never overlap.
- Full map (count 64): allocation of 4 gives indices 0..3 when the map is all ones.
- Empty map: `o_alloc_vld = 0`. Any nonzero `i_alloc_cnt` gives `o_alloc_gnt = 0`. Frees are still accepted.
- Partial availability, e.g. count 2 with request 3: no grant, and no entries are consumed.
- Simultaneous alloc and free of different entries in one cycle: both apply. Count = old − granted + freed.
- Reset or flush mid-operation: the in-flight grant is discarded, and there is no partial update.

## Structure
- Shared package: `FL_ENTRY_NUM = 64`, `FL_IDX_W = 6`, `FL_LANES = 4`, `FL_CNT_W = 7`.
- One sub-module: instantiate `gnrl_pecdr_64sel4_module` on the registered map.
  - Its selects are undefined when fewer than k+1 bits are set, so every use must be gated by `o_alloc_vld`.
- Popcount and the one-hot decoders stay local. Only map, count and `o_dbl_free` are flops.

## Test plan
- Reset, then request 4 → gnt=1, indices 0,1,2,3. Next cycle count=60 and indices 4,5,6,7.
- Allocate down to count=2, then request 3 → gnt=0, vld=4'b0011, count stays 2. Request 2 → gnt=1, count=0, `o_empty`=1.
- With the map empty, free indices 9 and 40 → same cycle vld=0. Next cycle count=2, indices 9, 40.
- Same cycle: allocate 2 (indices 4,5) and free index 0, with 0 allocated earlier → next map clears 4 and 5, sets 0. Count changes by −1.
- Free index 7 while it is already free, or free lanes 0 and 1 both at index 12 → `o_dbl_free`=1 for exactly one cycle.
- `i_flush` with map 64'h0000_0000_0000_00F0 while requesting 4 → gnt=0. Next cycle count=4, indices 4,5,6,7. Assert `rst` together with `i_flush` → reset map wins.

Source files
------------

// File: rtl/gnrl_freelist_64x4_pkg.sv
// Shared sizing constants and popcount helper for the 64-entry free list.
// Pure definitions; no state, no latency, no flow control.
package gnrl_freelist_64x4_pkg;

   localparam int FL_ENTRY_NUM = 64;
   localparam int FL_IDX_W     = 6;
   localparam int FL_LANES     = 4;
   localparam int FL_CNT_W     = 7;

   function automatic logic [FL_CNT_W-1:0] fl_popcount(input logic [FL_ENTRY_NUM-1:0] map);
      logic [FL_CNT_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < FL_ENTRY_NUM; i++) begin
         cnt = cnt + {{(FL_CNT_W-1){1'b0}}, map[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/gnrl_pecdr_64sel4_module.sv
// Selects the four lowest-indexed set bits of a 64-bit map; purely combinational.
// No flow control: a select is undefined when fewer than k+1 bits are set.
module gnrl_pecdr_64sel4_module
   import gnrl_freelist_64x4_pkg::*;
(
   input  logic [FL_ENTRY_NUM-1:0] map,
   output logic [FL_IDX_W-1:0]     sel_0,
   output logic [FL_IDX_W-1:0]     sel_1,
   output logic [FL_IDX_W-1:0]     sel_2,
   output logic [FL_IDX_W-1:0]     sel_3
);

   logic [2:0] seen;

   always_comb begin
      sel_0 = '0;
      sel_1 = '0;
      sel_2 = '0;
      sel_3 = '0;
      seen  = 3'd0;
      for (int i = 0; i < FL_ENTRY_NUM; i++) begin
         if (map[i]) begin
            case (seen)
               3'd0:    sel_0 = FL_IDX_W'(i);
               3'd1:    sel_1 = FL_IDX_W'(i);
               3'd2:    sel_2 = FL_IDX_W'(i);
               3'd3:    sel_3 = FL_IDX_W'(i);
               default: ;
            endcase
            if (seen != 3'd4) seen = seen + 3'd1;
         end
      end
   end

endmodule

// File: rtl/gnrl_freelist_64x4_module.sv
// 64-entry free list: grants up to 4 lowest free entries (0-cycle), reclaims up to 4 (1-cycle).
// All-or-nothing grant; frees never stall; flush restores the map, reset beats flush.
module gnrl_freelist_64x4_module
   import gnrl_freelist_64x4_pkg::*;
#(
   parameter logic [FL_ENTRY_NUM-1:0] RST_FREE_MAP = '1
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_flush,
   input  logic [FL_ENTRY_NUM-1:0] i_flush_free_map,
   input  logic [2:0]              i_alloc_cnt,
   output logic                    o_alloc_gnt,
   output logic [FL_LANES-1:0]     o_alloc_vld,
   output logic [FL_IDX_W-1:0]     o_alloc_idx_0,
   output logic [FL_IDX_W-1:0]     o_alloc_idx_1,
   output logic [FL_IDX_W-1:0]     o_alloc_idx_2,
   output logic [FL_IDX_W-1:0]     o_alloc_idx_3,
   input  logic [FL_LANES-1:0]     i_free_vld,
   input  logic [FL_IDX_W-1:0]     i_free_idx_0,
   input  logic [FL_IDX_W-1:0]     i_free_idx_1,
   input  logic [FL_IDX_W-1:0]     i_free_idx_2,
   input  logic [FL_IDX_W-1:0]     i_free_idx_3,
   output logic [FL_CNT_W-1:0]     o_free_cnt,
   output logic                    o_empty,
   output logic                    o_dbl_free
);

   logic [FL_ENTRY_NUM-1:0] map_q;
   logic [FL_CNT_W-1:0]     free_cnt_q;
   logic                    dbl_free_q;

   logic [2:0]              alloc_cnt_sat;
   logic [FL_IDX_W-1:0]     sel      [FL_LANES];
   logic [FL_IDX_W-1:0]     free_idx [FL_LANES];
   logic [FL_ENTRY_NUM-1:0] alloc_mask;
   logic [FL_ENTRY_NUM-1:0] free_mask;
   logic [FL_ENTRY_NUM-1:0] next_map;
   logic                    dbl_det;

   gnrl_pecdr_64sel4_module u_pecdr (
      .map   (map_q),
      .sel_0 (sel[0]),
      .sel_1 (sel[1]),
      .sel_2 (sel[2]),
      .sel_3 (sel[3])
   );

   assign free_idx[0] = i_free_idx_0;
   assign free_idx[1] = i_free_idx_1;
   assign free_idx[2] = i_free_idx_2;
   assign free_idx[3] = i_free_idx_3;

   assign o_alloc_idx_0 = sel[0];
   assign o_alloc_idx_1 = sel[1];
   assign o_alloc_idx_2 = sel[2];
   assign o_alloc_idx_3 = sel[3];

   // Requests of 5..7 are clamped to the lane count.
   assign alloc_cnt_sat = (i_alloc_cnt > 3'd4) ? 3'd4 : i_alloc_cnt;
   assign o_alloc_gnt   = ~i_flush & (free_cnt_q >= {4'b0000, alloc_cnt_sat});

   always_comb begin
      o_alloc_vld = '0;
      for (int k = 0; k < FL_LANES; k++) begin
         o_alloc_vld[k] = (free_cnt_q > FL_CNT_W'(k));
      end
   end

   // A granted lane is always backed by a real free bit, so its select is safe to decode.
   always_comb begin
      alloc_mask = '0;
      for (int k = 0; k < FL_LANES; k++) begin
         if (o_alloc_gnt && (3'(k) < alloc_cnt_sat)) alloc_mask[sel[k]] = 1'b1;
      end
   end

   always_comb begin
      free_mask = '0;
      dbl_det   = 1'b0;
      for (int k = 0; k < FL_LANES; k++) begin
         if (i_free_vld[k]) begin
            if (map_q[free_idx[k]] || free_mask[free_idx[k]]) dbl_det = 1'b1;
            free_mask[free_idx[k]] = 1'b1;
         end
      end
   end

   assign next_map = (map_q & ~alloc_mask) | free_mask;

   always_ff @(posedge clk) begin
      if (rst) begin
         map_q      <= RST_FREE_MAP;
         free_cnt_q <= fl_popcount(RST_FREE_MAP);
         dbl_free_q <= 1'b0;
      end else if (i_flush) begin
         map_q      <= i_flush_free_map;
         free_cnt_q <= fl_popcount(i_flush_free_map);
         dbl_free_q <= 1'b0;
      end else begin
         map_q      <= next_map;
         free_cnt_q <= fl_popcount(next_map);
         dbl_free_q <= dbl_det;
      end
   end

   assign o_free_cnt = free_cnt_q;
   assign o_empty    = (free_cnt_q == '0);
   assign o_dbl_free = dbl_free_q;

endmodule

// File: tb/tb_gnrl_freelist_64x4_module.sv
// Directed scoreboard bench for the 64x4 free list: driver queues hand-computed
// expectations per cycle, a monitor pops and compares the DUT outputs.
module tb_gnrl_freelist_64x4_module;

   localparam int CG  = 1;
   localparam int CV  = 2;
   localparam int CI  = 4;
   localparam int CC  = 8;
   localparam int CD  = 16;
   localparam int ALL = 31;

   typedef struct {
      string           nm;
      int              ck;
      logic            gnt;
      logic [3:0]      vld;
      int              nidx;
      logic [3:0][5:0] idx;
      logic [6:0]      cnt;
      logic            dbl;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_flush;
   logic [63:0] i_flush_free_map;
   logic [2:0]  i_alloc_cnt;
   logic        o_alloc_gnt;
   logic [3:0]  o_alloc_vld;
   logic [5:0]  o_alloc_idx_0, o_alloc_idx_1, o_alloc_idx_2, o_alloc_idx_3;
   logic [3:0]  i_free_vld;
   logic [5:0]  i_free_idx_0, i_free_idx_1, i_free_idx_2, i_free_idx_3;
   logic [6:0]  o_free_cnt;
   logic        o_empty;
   logic        o_dbl_free;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   gnrl_freelist_64x4_module dut (
      .clk              (clk),
      .rst              (rst),
      .i_flush          (i_flush),
      .i_flush_free_map (i_flush_free_map),
      .i_alloc_cnt      (i_alloc_cnt),
      .o_alloc_gnt      (o_alloc_gnt),
      .o_alloc_vld      (o_alloc_vld),
      .o_alloc_idx_0    (o_alloc_idx_0),
      .o_alloc_idx_1    (o_alloc_idx_1),
      .o_alloc_idx_2    (o_alloc_idx_2),
      .o_alloc_idx_3    (o_alloc_idx_3),
      .i_free_vld       (i_free_vld),
      .i_free_idx_0     (i_free_idx_0),
      .i_free_idx_1     (i_free_idx_1),
      .i_free_idx_2     (i_free_idx_2),
      .i_free_idx_3     (i_free_idx_3),
      .o_free_cnt       (o_free_cnt),
      .o_empty          (o_empty),
      .o_dbl_free       (o_dbl_free)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input string fld, input logic [63:0] act, input logic [63:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s.%s got %0h expected %0h", nm, fld, act, expv);
      end
   endtask

   task automatic drv(input logic r, input logic fl, input logic [63:0] fmap, input logic [2:0] acnt,
                      input logic [3:0] fv, input logic [5:0] f0, input logic [5:0] f1,
                      input logic [5:0] f2, input logic [5:0] f3);
      rst = r; i_flush = fl; i_flush_free_map = fmap; i_alloc_cnt = acnt;
      i_free_vld = fv; i_free_idx_0 = f0; i_free_idx_1 = f1; i_free_idx_2 = f2; i_free_idx_3 = f3;
   endtask

   task automatic expect_out(input string nm, input int ck, input logic gnt, input logic [3:0] vld,
                             input int nidx, input logic [5:0] e0, input logic [5:0] e1,
                             input logic [5:0] e2, input logic [5:0] e3,
                             input logic [6:0] cnt, input logic dbl);
      exp_t e;
      e.nm = nm; e.ck = ck; e.gnt = gnt; e.vld = vld; e.nidx = nidx;
      e.idx[0] = e0; e.idx[1] = e1; e.idx[2] = e2; e.idx[3] = e3;
      e.cnt = cnt; e.dbl = dbl;
      q.push_back(e);
   endtask

   // Monitor: samples 2 time units after the driver updates inputs on the falling edge.
   initial begin
      exp_t e;
      logic [3:0][5:0] act_idx;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            act_idx = {o_alloc_idx_3, o_alloc_idx_2, o_alloc_idx_1, o_alloc_idx_0};
            if ((e.ck & CG) != 0) chk(e.nm, "gnt", 64'(o_alloc_gnt), 64'(e.gnt));
            if ((e.ck & CV) != 0) chk(e.nm, "vld", 64'(o_alloc_vld), 64'(e.vld));
            if ((e.ck & CI) != 0) begin
               for (int k = 0; k < e.nidx; k++) chk(e.nm, $sformatf("idx%0d", k), 64'(act_idx[k]), 64'(e.idx[k]));
            end
            if ((e.ck & CC) != 0) begin
               chk(e.nm, "cnt", 64'(o_free_cnt), 64'(e.cnt));
               chk(e.nm, "empty", 64'(o_empty), 64'(e.cnt == 7'd0));
            end
            if ((e.ck & CD) != 0) chk(e.nm, "dbl", 64'(o_dbl_free), 64'(e.dbl));
         end
      end
   end

   initial begin
      drv(1'b1, 1'b0, 64'h0, 3'd0, 4'h0, 6'd0, 6'd0, 6'd0, 6'd0);
      @(negedge clk);
      repeat (2) begin
         drv(1'b1, 1'b0, 64'h0, 3'd0, 4'h0, 6'd0, 6'd0, 6'd0, 6'd0);
         expect_out("reset", 0, 1'b0, 4'h0, 0, 6'd0, 6'd0, 6'd0, 6'd0, 7'd0, 1'b0);
         @(negedge clk);
      end

      drv(1'b0, 1'b0, 64'h0, 3'd4, 4'h0, 6'd0, 6'd0, 6'd0, 6'd0);
      expect_out("rst_alloc4", ALL, 1'b1, 4'hF, 4, 6'd0, 6'd1, 6'd2, 6'd3, 7'd64, 1'b0);
      @(negedge clk);

      for (int j = 0; j < 14; j++) begin
         drv(1'b0, 1'b0, 64'h0, 3'd4, 4'h0, 6'd0, 6'd0, 6'd0, 6'd0);
         expect_out($sformatf("drain%0d", j), ALL, 1'b1, 4'hF, 4, 6'(4+4*j), 6'(5+4*j),
                    6'(6+4*j), 6'(7+4*j), 7'(60-4*j), 1'b0);
         @(negedge clk);
      end

      drv(1'b0, 1'b0, 64'h0, 3'd2, 4'h0, 6'd0, 6'd0, 6'd0, 6'd0);
      expect_out("part_a2", ALL, 1'b1, 4'hF, 4, 6'd60, 6'd61, 6'd62, 6'd63, 7'd4, 1'b0);
      @(negedge clk);
      drv(1'b0, 1'b0, 64'h0, 3'd3, 4'h0, 6'd0, 6'd0, 6'd0, 6'd0);
      expect_out("part_a3", ALL, 1'b0, 4'b0011, 2, 6'd62, 6'd63, 6'd0, 6'd0, 7'd2, 1'b0);
      @(negedge clk);
      drv(1'b0, 1'b0, 64'h0, 3'd2, 4'h0, 6'd0, 6'd0, 6'd0, 6'd0);
      expect_out("part_a2b", ALL, 1'b1, 4'b0011, 2, 6'd62, 6'd63, 6'd0, 6'd0, 7'd2, 1'b0);
      @(negedge clk);

      drv(1'b0, 1'b0, 64'h0, 3'd1, 4'b0011, 6'd9, 6'd40, 6'd0, 6'd0);
      expect_out("empty_free", ALL, 1'b0, 4'h0, 0, 6'd0, 6'd0, 6'd0, 6'd0, 7'd0, 1'b0);
      @(negedge clk);
      drv(1'b0, 1'b0, 64'h0, 3'd0, 4'b0011, 6'd4, 6'd5, 6'd0, 6'd0);
      expect_out("freed", ALL, 1'b1, 4'b0011, 2, 6'd9, 6'd40, 6'd0, 6'd0, 7'd2, 1'b0);
      @(negedge clk);

      drv(1'b0, 1'b0, 64'h0, 3'd2, 4'b0001, 6'd0, 6'd0, 6'd0, 6'd0);
      expect_out("mix_pre", ALL, 1'b1, 4'hF, 4, 6'd4, 6'd5, 6'd9, 6'd40, 7'd4, 1'b0);
      @(negedge clk);
      drv(1'b0, 1'b0, 64'h0, 3'd0, 4'h0, 6'd0, 6'd0, 6'd0, 6'd0);
      expect_out("mix_post", ALL, 1'b1, 4'b0111, 3, 6'd0, 6'd9, 6'd40, 6'd0, 7'd3, 1'b0);
      @(negedge clk);

      drv(1'b0, 1'b0, 64'h0, 3'd0, 4'b0001, 6'd9, 6'd0, 6'd0, 6'd0);
      expect_out("dbl_map_req", ALL, 1'b1, 4'b0111, 3, 6'd0, 6'd9, 6'd40, 6'd0, 7'd3, 1'b0);
      @(negedge clk);
      drv(1'b0, 1'b0, 64'h0, 3'd0, 4'h0, 6'd0, 6'd0, 6'd0, 6'd0);
      expect_out("dbl_map", ALL, 1'b1, 4'b0111, 3, 6'd0, 6'd9, 6'd40, 6'd0, 7'd3, 1'b1);
      @(negedge clk);
      drv(1'b0, 1'b0, 64'h0, 3'd0, 4'b0011, 6'd12, 6'd12, 6'd0, 6'd0);
      expect_out("dbl_map_clr", ALL, 1'b1, 4'b0111, 3, 6'd0, 6'd9, 6'd40, 6'd0, 7'd3, 1'b0);
      @(negedge clk);
      drv(1'b0, 1'b0, 64'h0, 3'd0, 4'h0, 6'd0, 6'd0, 6'd0, 6'd0);
      expect_out("dbl_dup", ALL, 1'b1, 4'hF, 4, 6'd0, 6'd9, 6'd12, 6'd40, 7'd4, 1'b1);
      @(negedge clk);

      drv(1'b0, 1'b0, 64'h0, 3'd7, 4'h0, 6'd0, 6'd0, 6'd0, 6'd0);
      expect_out("alloc7", ALL, 1'b1, 4'hF, 4, 6'd0, 6'd9, 6'd12, 6'd40, 7'd4, 1'b0);
      @(negedge clk);

      drv(1'b0, 1'b1, 64'h0000_0000_0000_00F0, 3'd4, 4'b0011, 6'd1, 6'd1, 6'd0, 6'd0);
      expect_out("flush", ALL, 1'b0, 4'h0, 0, 6'd0, 6'd0, 6'd0, 6'd0, 7'd0, 1'b0);
      @(negedge clk);
      drv(1'b0, 1'b0, 64'h0, 3'd0, 4'h0, 6'd0, 6'd0, 6'd0, 6'd0);
      expect_out("flush_post", ALL, 1'b1, 4'hF, 4, 6'd4, 6'd5, 6'd6, 6'd7, 7'd4, 1'b0);
      @(negedge clk);

      drv(1'b1, 1'b1, 64'h0000_0000_0000_00F0, 3'd4, 4'h0, 6'd0, 6'd0, 6'd0, 6'd0);
      expect_out("rst_flush", ALL, 1'b0, 4'hF, 4, 6'd4, 6'd5, 6'd6, 6'd7, 7'd4, 1'b0);
      @(negedge clk);
      drv(1'b0, 1'b0, 64'h0, 3'd0, 4'h0, 6'd0, 6'd0, 6'd0, 6'd0);
      expect_out("rst_post", ALL, 1'b1, 4'hF, 4, 6'd0, 6'd1, 6'd2, 6'd3, 7'd64, 1'b0);
      @(negedge clk);

      repeat (2) @(negedge clk);
      #4;
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain_queue got %0d pending expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #50000;
      n_fail++;
      $display("FAIL timeout got running expected finished");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
